// File: rtl/axi_parity_engine_if.sv
// AXI4-Lite bus bundle for the parity engine register slave.
// The slave modport is the DUT view; master is the bus driver view.
interface axi_parity_engine_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 7
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid,
        output arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid,
        input  arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_parity_engine.sv
// AXI4-Lite parity scanner: computes per-word and aggregate parity of DATA regs.
// Define PARITY_ENGINE_IRQ_EN to enable CTRL.IRQ_EN and the registered irq output.
module axi_parity_engine #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 7,
    parameter int NUM_WORDS          = 4
) (
    input  logic               s00_axi_aclk,
    input  logic               s00_axi_areset,
    axi_parity_engine_if.slave s00_axi,
    output logic               irq
);
    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int AW = C_S_AXI_ADDR_WIDTH;
    localparam int SW = DW / 8;
    localparam int IW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IW-1:0] LAST = IW'(NUM_WORDS - 1);

    typedef enum logic [1:0] {IDLE, SCAN, FIN} state_t;

    state_t               state;
    logic [IW-1:0]        scan_idx;
    logic [DW-1:0]        data_q [NUM_WORDS];
    logic                 odd_q;
    logic                 odd_lat;
    logic                 irq_en_q;
    logic                 done_q;
    logic                 agg_q;
    logic                 agg_acc;
    logic [NUM_WORDS-1:0] result_q;
    logic [NUM_WORDS-1:0] res_acc;
    logic [NUM_WORDS-1:0] res_next;
    logic                 word_par;
    logic                 agg_next;

    logic        busy;
    logic [31:0] wr_word;
    logic [31:0] rd_word;
    logic [31:0] rd_val;
    logic        wr_fire;
    logic        rd_fire;
    logic        wr_ctrl;
    logic        wr_stat;
    logic        wr_data_hit;
    logic        start_req;
    logic        clr_done;
    logic        data_we;
    logic        unused_bits;

    assign busy    = (state != IDLE);
    assign wr_word = 32'(s00_axi.awaddr[AW-1:2]);
    assign rd_word = 32'(s00_axi.araddr[AW-1:2]);

    assign wr_fire = s00_axi.awready & s00_axi.awvalid
                   & s00_axi.wready & s00_axi.wvalid;
    assign rd_fire = s00_axi.arready & s00_axi.arvalid;

    assign wr_ctrl     = (wr_word == 32'd0);
    assign wr_stat     = (wr_word == 32'd1);
    assign wr_data_hit = (wr_word >= 32'd4)
                       && (wr_word < 32'(4 + NUM_WORDS));

    assign start_req = wr_fire & wr_ctrl & s00_axi.wstrb[0]
                     & s00_axi.wdata[0] & ~busy;
    assign clr_done  = wr_fire & wr_stat & s00_axi.wstrb[0]
                     & s00_axi.wdata[1];
    assign data_we   = wr_fire & wr_data_hit & ~busy;

    assign unused_bits = ^{s00_axi.awprot, s00_axi.arprot,
                           s00_axi.awaddr[1:0], s00_axi.araddr[1:0]};

    assign word_par = ^data_q[scan_idx];
    assign agg_next = agg_acc ^ word_par;

    always_comb begin
        res_next = res_acc;
        res_next[scan_idx] = word_par ^ odd_lat;
    end

    always_comb begin
        rd_val = '0;
        if (rd_word == 32'd0) begin
            rd_val[2:0] = {irq_en_q, odd_q, 1'b0};
        end else if (rd_word == 32'd1) begin
            rd_val[2:0] = {agg_q, done_q, busy};
        end else if (rd_word == 32'd2) begin
            rd_val[NUM_WORDS-1:0] = result_q;
        end else begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                if (rd_word == 32'(i + 4)) rd_val[DW-1:0] = data_q[i];
            end
        end
    end

    // Ready pulses for exactly one cycle; response holds until accepted.
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            s00_axi.awready <= 1'b0;
            s00_axi.wready  <= 1'b0;
            s00_axi.bvalid  <= 1'b0;
            s00_axi.bresp   <= 2'b00;
            s00_axi.arready <= 1'b0;
            s00_axi.rvalid  <= 1'b0;
            s00_axi.rresp   <= 2'b00;
            s00_axi.rdata   <= '0;
        end else begin
            s00_axi.awready <= s00_axi.awvalid & s00_axi.wvalid
                             & ~s00_axi.bvalid & ~s00_axi.awready;
            s00_axi.wready  <= s00_axi.awvalid & s00_axi.wvalid
                             & ~s00_axi.bvalid & ~s00_axi.awready;
            if (wr_fire) begin
                s00_axi.bvalid <= 1'b1;
                s00_axi.bresp  <= (busy && wr_data_hit) ? 2'b10 : 2'b00;
            end else if (s00_axi.bready) begin
                s00_axi.bvalid <= 1'b0;
            end
            s00_axi.arready <= s00_axi.arvalid & ~s00_axi.rvalid
                             & ~s00_axi.arready;
            if (rd_fire) begin
                s00_axi.rvalid <= 1'b1;
                s00_axi.rdata  <= rd_val[DW-1:0];
                s00_axi.rresp  <= 2'b00;
            end else if (s00_axi.rready) begin
                s00_axi.rvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            state    <= IDLE;
            scan_idx <= '0;
            odd_q    <= 1'b0;
            odd_lat  <= 1'b0;
            irq_en_q <= 1'b0;
            done_q   <= 1'b0;
            agg_q    <= 1'b0;
            agg_acc  <= 1'b0;
            result_q <= '0;
            res_acc  <= '0;
            for (int i = 0; i < NUM_WORDS; i++) data_q[i] <= '0;
        end else begin
            if (wr_fire && wr_ctrl && s00_axi.wstrb[0]) begin
                odd_q <= s00_axi.wdata[1];
`ifdef PARITY_ENGINE_IRQ_EN
                irq_en_q <= s00_axi.wdata[2];
`endif
            end
            if (data_we) begin
                for (int i = 0; i < NUM_WORDS; i++) begin
                    if (wr_word == 32'(i + 4)) begin
                        for (int b = 0; b < SW; b++) begin
                            if (s00_axi.wstrb[b])
                                data_q[i][8*b +: 8] <= s00_axi.wdata[8*b +: 8];
                        end
                    end
                end
            end
            if (clr_done) done_q <= 1'b0;
            // Results commit on the last scan step so they appear with FIN.
            unique case (state)
                IDLE: begin
                    if (start_req) begin
                        state    <= SCAN;
                        scan_idx <= '0;
                        odd_lat  <= s00_axi.wdata[1];
                        agg_acc  <= 1'b0;
                        res_acc  <= '0;
                    end
                end
                SCAN: begin
                    res_acc  <= res_next;
                    agg_acc  <= agg_next;
                    scan_idx <= scan_idx + 1'b1;
                    if (scan_idx == LAST) begin
                        state    <= FIN;
                        result_q <= res_next;
                        agg_q    <= agg_next ^ odd_lat;
                        done_q   <= 1'b1;
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef PARITY_ENGINE_IRQ_EN
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) irq <= 1'b0;
        else                irq <= done_q & irq_en_q;
    end
`else
    assign irq = 1'b0;
`endif
endmodule

// File: tb/tb_axi_parity_engine.sv
// Directed bench for axi_parity_engine: register map, scan latency,
// busy protection, byte strobes, back-pressure and mid-scan reset.
module tb_axi_parity_engine;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic irq;
    int   n_checks = 0;
    int   n_fail = 0;
    logic [31:0] rd;
    logic [1:0]  rr;
    logic [1:0]  br;

    axi_parity_engine_if #(.DATA_WIDTH(32), .ADDR_WIDTH(7)) bus ();

    axi_parity_engine #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(7),
        .NUM_WORDS(4)
    ) dut (
        .s00_axi_aclk(clk),
        .s00_axi_areset(rst),
        .s00_axi(bus),
        .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic axi_write(input logic [6:0] a, input logic [31:0] d,
                             input logic [3:0] s, output logic [1:0] resp);
        int n = 0;
        bus.awaddr = a; bus.wdata = d; bus.wstrb = s;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        while (!bus.awready && n < 30) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        resp = bus.bresp;
        if (n >= 30 || !bus.bvalid) begin
            n_checks++; n_fail++;
            $display("FAIL write_handshake addr=%h: bvalid=%b want 1", a, bus.bvalid);
        end
    endtask

    task automatic axi_read(input logic [6:0] a, output logic [31:0] d,
                            output logic [1:0] resp);
        int n = 0;
        bus.araddr = a; bus.arvalid = 1'b1;
        while (!bus.arready && n < 30) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
        bus.arvalid = 1'b0;
        d = bus.rdata; resp = bus.rresp;
        if (n >= 30 || !bus.rvalid) begin
            n_checks++; n_fail++;
            $display("FAIL read_handshake addr=%h: rvalid=%b want 1", a, bus.rvalid);
        end
    endtask

    task automatic test_reset();
        n_checks++;
        if (irq !== 1'b0 || bus.bvalid !== 1'b0 || bus.rvalid !== 1'b0
            || bus.awready !== 1'b0 || bus.arready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: irq=%b bv=%b rv=%b awr=%b arr=%b want 0",
                     irq, bus.bvalid, bus.rvalid, bus.awready, bus.arready);
        end
        axi_read(7'h04, rd, rr);
        n_checks++;
        if (rd !== 32'h0) begin
            n_fail++; $display("FAIL reset_status: got %h want 0", rd);
        end
        axi_read(7'h08, rd, rr);
        n_checks++;
        if (rd !== 32'h0) begin
            n_fail++; $display("FAIL reset_result: got %h want 0", rd);
        end
        axi_read(7'h10, rd, rr);
        n_checks++;
        if (rd !== 32'h0) begin
            n_fail++; $display("FAIL reset_data0: got %h want 0", rd);
        end
    endtask

    task automatic test_scan_even();
        for (int i = 0; i < 4; i++) begin
            axi_write(7'(16 + 4 * i), 32'(i + 1), 4'hF, br);
            n_checks++;
            if (br !== 2'b00) begin
                n_fail++; $display("FAIL data_wr_resp[%0d]: got %b want 00", i, br);
            end
        end
        axi_read(7'h18, rd, rr);
        n_checks++;
        if (rd !== 32'h3) begin
            n_fail++; $display("FAIL data2_readback: got %h want 3", rd);
        end
        axi_write(7'h00, 32'h1, 4'hF, br);
        n_checks++;
        if (dut.busy !== 1'b1) begin
            n_fail++; $display("FAIL busy_t1: got %b want 1", dut.busy);
        end
        repeat (3) begin @(posedge clk); #1; end
        n_checks++;
        if (dut.done_q !== 1'b0) begin
            n_fail++; $display("FAIL done_early_t4: got %b want 0", dut.done_q);
        end
        @(posedge clk); #1;
        n_checks++;
        if (dut.done_q !== 1'b1 || dut.busy !== 1'b1 || dut.result_q !== 4'hB
            || dut.agg_q !== 1'b1) begin
            n_fail++;
            $display("FAIL done_t5: done=%b busy=%b res=%h agg=%b want 1 1 b 1",
                     dut.done_q, dut.busy, dut.result_q, dut.agg_q);
        end
        @(posedge clk); #1;
        n_checks++;
        if (dut.busy !== 1'b0) begin
            n_fail++; $display("FAIL busy_t6: got %b want 0", dut.busy);
        end
        axi_read(7'h08, rd, rr);
        n_checks++;
        if (rd !== 32'hB) begin
            n_fail++; $display("FAIL result_even: got %h want b", rd);
        end
        axi_read(7'h04, rd, rr);
        n_checks++;
        if (rd !== 32'h6) begin
            n_fail++; $display("FAIL status_even: got %h want 6", rd);
        end
    endtask

    task automatic test_scan_odd();
        axi_write(7'h04, 32'h2, 4'hF, br);
        axi_read(7'h04, rd, rr);
        n_checks++;
        if (rd !== 32'h4) begin
            n_fail++; $display("FAIL done_w1c: got %h want 4", rd);
        end
        axi_write(7'h00, 32'h3, 4'hF, br);
        repeat (8) @(posedge clk);
        #1;
        axi_read(7'h08, rd, rr);
        n_checks++;
        if (rd !== 32'h4) begin
            n_fail++; $display("FAIL result_odd: got %h want 4", rd);
        end
        axi_read(7'h04, rd, rr);
        n_checks++;
        if (rd !== 32'h2) begin
            n_fail++; $display("FAIL status_odd: got %h want 2", rd);
        end
        axi_read(7'h00, rd, rr);
        n_checks++;
        if (rd !== 32'h2) begin
            n_fail++; $display("FAIL ctrl_readback: got %h want 2", rd);
        end
    endtask

    task automatic test_busy_write();
        axi_write(7'h00, 32'h1, 4'hF, br);
        axi_write(7'h10, 32'hFF, 4'hF, br);
        n_checks++;
        if (br !== 2'b10) begin
            n_fail++; $display("FAIL busy_data_resp: got %b want 10", br);
        end
        axi_write(7'h00, 32'h1, 4'hF, br);
        n_checks++;
        if (br !== 2'b00) begin
            n_fail++; $display("FAIL busy_start_resp: got %b want 00", br);
        end
        repeat (8) @(posedge clk);
        #1;
        axi_read(7'h10, rd, rr);
        n_checks++;
        if (rd !== 32'h1) begin
            n_fail++; $display("FAIL busy_data_kept: got %h want 1", rd);
        end
        axi_read(7'h08, rd, rr);
        n_checks++;
        if (rd !== 32'hB) begin
            n_fail++; $display("FAIL result_after_busy: got %h want b", rd);
        end
    endtask

    task automatic test_wstrb_unmapped();
        axi_write(7'h14, 32'hAABBCCDD, 4'hF, br);
        axi_write(7'h14, 32'h11223344, 4'h5, br);
        axi_read(7'h14, rd, rr);
        n_checks++;
        if (rd !== 32'hAA22CC44) begin
            n_fail++; $display("FAIL wstrb_merge: got %h want aa22cc44", rd);
        end
        axi_write(7'h40, 32'hDEADBEEF, 4'hF, br);
        n_checks++;
        if (br !== 2'b00) begin
            n_fail++; $display("FAIL unmapped_bresp: got %b want 00", br);
        end
        axi_read(7'h40, rd, rr);
        n_checks++;
        if (rd !== 32'h0 || rr !== 2'b00) begin
            n_fail++; $display("FAIL unmapped_read: got %h/%b want 0/00", rd, rr);
        end
    endtask

    task automatic test_bready_stall();
        int bad = 0;
        bus.bready = 1'b0;
        axi_write(7'h18, 32'h55, 4'hF, br);
        bus.awaddr = 7'h18; bus.wdata = 32'h66; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (bus.bvalid !== 1'b1 || bus.awready !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++; $display("FAIL bready_stall: %0d bad cycles want 0", bad);
        end
        bus.bready = 1'b1;
        axi_write(7'h18, 32'h66, 4'hF, br);
        axi_read(7'h18, rd, rr);
        n_checks++;
        if (rd !== 32'h66) begin
            n_fail++; $display("FAIL stall_second_write: got %h want 66", rd);
        end
    endtask

    task automatic test_irq();
        axi_write(7'h00, 32'h5, 4'hF, br);
        repeat (8) @(posedge clk);
        #1;
`ifdef PARITY_ENGINE_IRQ_EN
        n_checks++;
        if (irq !== 1'b1) begin
            n_fail++; $display("FAIL irq_set: got %b want 1", irq);
        end
        axi_write(7'h04, 32'h2, 4'hF, br);
        @(posedge clk); #1;
        n_checks++;
        if (irq !== 1'b0 || dut.done_q !== 1'b0) begin
            n_fail++; $display("FAIL irq_clear: irq=%b done=%b want 0 0", irq, dut.done_q);
        end
`else
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++; $display("FAIL irq_tied: got %b want 0", irq);
        end
        axi_read(7'h00, rd, rr);
        n_checks++;
        if (rd !== 32'h0) begin
            n_fail++; $display("FAIL ctrl_irq_en_ignored: got %h want 0", rd);
        end
`endif
    endtask

    task automatic test_reset_mid_scan();
        axi_write(7'h00, 32'h1, 4'hF, br);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++;
        if (dut.busy !== 1'b0) begin
            n_fail++; $display("FAIL midscan_busy: got %b want 0", dut.busy);
        end
        axi_read(7'h04, rd, rr);
        n_checks++;
        if (rd !== 32'h0) begin
            n_fail++; $display("FAIL midscan_status: got %h want 0", rd);
        end
        axi_read(7'h08, rd, rr);
        n_checks++;
        if (rd !== 32'h0) begin
            n_fail++; $display("FAIL midscan_result: got %h want 0", rd);
        end
        for (int i = 0; i < 4; i++) begin
            axi_read(7'(16 + 4 * i), rd, rr);
            n_checks++;
            if (rd !== 32'h0) begin
                n_fail++; $display("FAIL midscan_data[%0d]: got %h want 0", i, rd);
            end
        end
        axi_write(7'h00, 32'h1, 4'hF, br);
        repeat (8) @(posedge clk);
        #1;
        axi_read(7'h08, rd, rr);
        n_checks++;
        if (rd !== 32'h0) begin
            n_fail++; $display("FAIL zero_scan_result: got %h want 0", rd);
        end
        axi_read(7'h04, rd, rr);
        n_checks++;
        if (rd !== 32'h2) begin
            n_fail++; $display("FAIL zero_scan_status: got %h want 2", rd);
        end
    endtask

    initial begin
        bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
        bus.bready = 1'b1; bus.araddr = '0; bus.arprot = '0;
        bus.arvalid = 1'b0; bus.rready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_scan_even();
        test_scan_odd();
        test_busy_write();
        test_wstrb_unmapped();
        test_bready_stall();
        test_irq();
        test_reset_mid_scan();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/axi_parity_engine.md
AXI_PARITY_ENGINE -- requirements
Module: axi_parity_engine

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, AXI data width and width of each data word (8..32).
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 7, AXI byte-address width.
REQ-003 SHALL have parameter NUM_WORDS, default 4, number of data registers scanned (1..16).
REQ-004 SHALL have port s00_axi_aclk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port s00_axi_areset, input, 1, reset, synchronous, active-high.
REQ-006 SHALL have ports s00_axi_awaddr/awprot/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready, araddr/arprot/arvalid/arready, rdata/rresp/rvalid/rready, with standard AXI4-Lite slave directions and widths.
REQ-007 SHALL have port irq, output, 1, level interrupt on scan completion.

Function
REQ-008 Register map SHALL be:
- 0x00 CTRL: bit0 START (write-1 pulse, reads 0), bit1 ODD, bit2 IRQ_EN.
- 0x04 STATUS: bit0 BUSY (RO), bit1 DONE (write-1-to-clear), bit2 AGG (RO).
- 0x08 RESULT: bit i = parity of DATA[i] (RO).
- 0x10+4*i: DATA[i], read/write.
REQ-009 Write channel SHALL assert awready and wready together for exactly one cycle once awvalid and wvalid are both high and bvalid is low; bvalid rises the next cycle and holds until bready.
REQ-010 Read channel SHALL assert arready for one cycle when arvalid is high and rvalid is low; rvalid with rdata rises the next cycle and holds until rready.
REQ-011 wstrb SHALL byte-mask writes to CTRL and DATA.
REQ-012 Unmapped addresses SHALL read 0 and ignore writes, with resp OKAY (2'b00).
REQ-013 FSM states SHALL be IDLE, SCAN and FIN:
- IDLE->SCAN on accepted START=1 write.
- SCAN: word index 0..NUM_WORDS-1, one word per cycle.
- SCAN->FIN after index NUM_WORDS-1.
- FIN->IDLE unconditionally.
REQ-014 BUSY SHALL be 1 in SCAN and FIN.
REQ-015 Parity bit i SHALL be the XOR of DATA[i] (ODD=0), or its inverse (ODD=1); ODD SHALL be sampled at START.
REQ-016 AGG SHALL be the XOR of all scanned DATA bits, inverted when ODD=1.
REQ-017 Latency: START accepted in cycle T -> BUSY=1 at T+1 -> RESULT, AGG and DONE=1 at T+1+NUM_WORDS -> BUSY=0 at T+2+NUM_WORDS.
REQ-018 RESULT and AGG SHALL hold their values until the next scan completes.
REQ-019 While BUSY, a START write SHALL be ignored with bresp OKAY.
REQ-020 While BUSY, DATA writes SHALL be dropped with bresp SLVERR (2'b10).
REQ-021 DONE set by FIN and a W1C write in the same cycle SHALL leave DONE=1 (set wins).
REQ-022 RESULT bits NUM_WORDS..31 SHALL read 0.

Reset
REQ-023 On s00_axi_areset=1, the following SHALL be 0 at the next edge, including mid-scan:
- all registers, the FSM (IDLE) and the index counter;
- awready, wready, bvalid, arready, rvalid and irq.
REQ-024 bresp and rresp SHALL reset to 2'b00.

Configuration
REQ-025 Macro PARITY_ENGINE_IRQ_EN defined: irq = DONE & IRQ_EN, registered.
REQ-026 Macro PARITY_ENGINE_IRQ_EN absent: irq is tied 0 and CTRL bit2 reads 0 and ignores writes.

Verification
REQ-027 NUM_WORDS=4: write DATA = 0x1, 0x2, 0x3, 0x4, START with ODD=0 -> RESULT=0xB, AGG=1, DONE=1 exactly 5 cycles after START acceptance.
REQ-028 Same data, START with ODD=1 -> RESULT=0x4, AGG=0.
REQ-029 Write DATA[0] while BUSY -> bresp=2'b10; DATA[0] is unchanged on readback.
REQ-030 Assert reset for 1 cycle during SCAN -> BUSY=0, RESULT=0, STATUS=0, all DATA=0; a later START produces RESULT=0x0.
REQ-031 With PARITY_ENGINE_IRQ_EN and IRQ_EN=1: scan completes -> irq=1; write STATUS=0x2 -> DONE=0 and irq=0 one cycle later.
REQ-032 bready held low for 10 cycles -> bvalid stays high, no new write accepted; read of 0x40 -> rdata=0, rresp=2'b00.
